spi_peripheral: RTL

- SPI responder (target) side of the team's SPI link. Pairs with spi_controller on the other end of the bus.
- Oversamples the bus (p_clk, p_sel_n, copi) in the sys_clk domain and shifts one SPI_DATA_WIDTH word in each direction per select window, LSB first.
- Exposes a one-deep transmit buffer with a valid/ready handshake, and a received-word strobe, to local logic.

---
 rtl/spi_peripheral_if.sv | 28 ++
 rtl/spi_peripheral.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral_if.sv
// SPI responder bus bundle: the SPI pins plus the local transmit/receive
// handshake. The slave modport is the peripheral's view of it; the master
// modport is the view of whatever drives the SPI pins and the local side.
interface spi_peripheral_if #(
    parameter int SPI_DATA_WIDTH = 8
);
    logic                      p_clk;
    logic                      p_sel_n;
    logic                      copi;
    logic                      cipo;
    logic                      cipo_oe;
    logic [SPI_DATA_WIDTH-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [SPI_DATA_WIDTH-1:0] rx_data;
    logic                      rx_valid;
    logic                      frame_abort;

    modport slave (
        input  p_clk, p_sel_n, copi, tx_data, tx_valid,
        output cipo, cipo_oe, tx_ready, rx_data, rx_valid, frame_abort
    );

    modport master (
        output p_clk, p_sel_n, copi, tx_data, tx_valid,
        input  cipo, cipo_oe, tx_ready, rx_data, rx_valid, frame_abort
    );
endinterface

// File: rtl/spi_peripheral.sv
// SPI responder (target). Oversamples p_clk / p_sel_n / copi in the sys_clk
// domain and exchanges one SPI_DATA_WIDTH word each way per select window,
// LSB first. Local logic hands over the next transmit word through a one-deep
// buffer (tx_valid/tx_ready) and sees each received word as rx_data/rx_valid.
// Optional sticky underrun/abort status register: define SPI_PERI_STATUS_EN.
module spi_peripheral #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter bit CPOL           = 1'b0,
    parameter bit CPHA           = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sync_rst_n,
`ifdef SPI_PERI_STATUS_EN
    input  logic             status_clr,
    output logic [1:0]       status,
`endif
    spi_peripheral_if.slave  bus
);

    localparam int W     = SPI_DATA_WIDTH;
    localparam int CNT_W = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        XFER,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Synchroniser and edge-detect flops
    logic p_clk_s1, p_clk_s2, p_clk_s3;
    logic sel_s1, sel_s2, sel_s3;
    logic copi_s1, copi_s2;

    // Edge events in the sys_clk domain
    logic lead_edge, trail_edge;
    logic sample_edge, drive_edge;
    logic sel_fall, sel_rise;

    // Datapath registers
    logic [W-1:0]     tx_buf;
    logic             tx_buf_full;
    logic [W-1:0]     tx_shift;
    logic [W-2:0]     rx_shift;
    logic [W-1:0]     rx_word;
    logic [W-1:0]     rx_data_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             rx_valid_q;
    logic             frame_abort_q;
    logic             active;

    // FSM control strobes
    logic load_frame;
    logic take_sample;
    logic shift_out;
    logic complete;
    logic abort;
    logic oe_c;
    logic cipo_c;

    // Derived signals
    logic [W-1:0] rx_next;
    logic         last_sample;
    logic         first_lead_hold;
    logic         tx_ready_c;
    logic         tx_accept;

    // Bring the SPI pins into sys_clk: two sync flops each, plus a third
    // on p_clk and p_sel_n so their edges can be detected.
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            p_clk_s1 <= 1'b0;
            p_clk_s2 <= 1'b0;
            p_clk_s3 <= 1'b0;
            sel_s1   <= 1'b0;
            sel_s2   <= 1'b0;
            sel_s3   <= 1'b0;
            copi_s1  <= 1'b0;
            copi_s2  <= 1'b0;
        end else begin
            p_clk_s1 <= bus.p_clk;
            p_clk_s2 <= p_clk_s1;
            p_clk_s3 <= p_clk_s2;
            sel_s1   <= bus.p_sel_n;
            sel_s2   <= sel_s1;
            sel_s3   <= sel_s2;
            copi_s1  <= bus.copi;
            copi_s2  <= copi_s1;
        end
    end

    // Leading edge leaves the idle level, trailing edge returns to it; CPHA
    // decides which of the two samples copi and which advances cipo.
    assign lead_edge   = (p_clk_s2 != CPOL) && (p_clk_s3 == CPOL);
    assign trail_edge  = (p_clk_s2 == CPOL) && (p_clk_s3 != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;
    assign sel_fall    = !sel_s2 && sel_s3;
    assign sel_rise    = sel_s2 && !sel_s3;

    // The word as it stands once the bit being sampled now is shifted in
    assign rx_next         = {copi_s2, rx_shift};
    assign last_sample     = (bit_cnt == CNT_W'(W - 1));
    // With CPHA=1 bit 0 is already on cipo, so the first leading edge
    // must not advance the shifter.
    assign first_lead_hold = CPHA && (bit_cnt == '0);

    assign tx_ready_c = active && !tx_buf_full;
    assign tx_accept  = bus.tx_valid && tx_ready_c;

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes, including the cipo
    // pad value and its output enable
    always_comb begin
        state_next  = state;
        load_frame  = 1'b0;
        take_sample = 1'b0;
        shift_out   = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;
        oe_c        = 1'b0;
        cipo_c      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_fall) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                oe_c       = 1'b1;
                cipo_c     = tx_buf_full & tx_buf[0];
                load_frame = 1'b1;
                if (sel_rise) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = XFER;
                end
            end
            XFER: begin
                oe_c   = 1'b1;
                cipo_c = tx_shift[0];
                if (sample_edge) begin
                    take_sample = 1'b1;
                    if (last_sample) begin
                        // A completing sample wins over a simultaneous deselect
                        complete   = 1'b1;
                        state_next = sel_rise ? IDLE : DONE;
                    end else if (sel_rise) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                    end
                end else if (sel_rise) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (drive_edge && !first_lead_hold) begin
                    shift_out = 1'b1;
                end
            end
            DONE: begin
                oe_c   = 1'b1;
                cipo_c = tx_shift[0];
                if (sel_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-deep transmit buffer: a new word may be accepted in any state,
    // and a word accepted in the LOAD cycle is kept for the next frame.
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            tx_buf      <= '0;
            tx_buf_full <= 1'b0;
            active      <= 1'b0;
        end else begin
            active <= 1'b1;
            if (tx_accept) begin
                tx_buf      <= bus.tx_data;
                tx_buf_full <= 1'b1;
            end else if (load_frame) begin
                tx_buf_full <= 1'b0;
            end
        end
    end

    // Frame shifters and bit counter; an empty buffer at frame start sends
    // all zeros.
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            if (load_frame) begin
                tx_shift <= tx_buf_full ? tx_buf : '0;
                bit_cnt  <= '0;
            end else if (shift_out) begin
                tx_shift <= {1'b0, tx_shift[W-1:1]};
            end
            if (take_sample) begin
                rx_shift <= rx_next[W-1:1];
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Received word and the completion/abort strobes
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            rx_valid_q    <= complete;
            frame_abort_q <= abort;
            if (complete) begin
                rx_data_q <= rx_next;
            end
        end
    end

    assign rx_word         = rx_data_q;
    assign bus.rx_data     = rx_word;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.tx_ready    = tx_ready_c;
    assign bus.cipo        = cipo_c;
    assign bus.cipo_oe     = oe_c;

`ifdef SPI_PERI_STATUS_EN
    logic [1:0] status_q;
    logic       underrun_evt;

    assign underrun_evt = load_frame && !tx_buf_full;

    // Sticky underrun/abort flags; a new event beats a simultaneous clear
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            status_q <= 2'b00;
        end else begin
            status_q[0] <= underrun_evt | (status_q[0] & ~status_clr);
            status_q[1] <= abort        | (status_q[1] & ~status_clr);
        end
    end

    assign status = status_q;
`endif

endmodule
